// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP definitions used by the UDP receive path.
// Holds the length field width and the output read-side state encoding.
package eth_pkg;

  localparam int eth_udp_length_width = 16;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/udp_to_axi_packer.sv
// Packs UDP payload bytes into words and writes them speculatively to the data RAM.
// A frame is committed on a good last byte, otherwise the speculative pointer is rolled back.
module udp_to_axi_packer
  import eth_pkg::*;
#(
  parameter int BYTES      = 4,
  parameter int DATA_DEPTH = 4096,
  parameter int AW         = $clog2(DATA_DEPTH),
  parameter int PW         = AW + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [eth_udp_length_width-1:0] udp_length,
  input  logic [7:0]                      udp_data,
  input  logic                            udp_valid,
  input  logic                            udp_last,
  input  logic [PW-1:0]                   rd_ptr,
  input  logic                            frame_full,
  output logic                            ram_we,
  output logic [AW-1:0]                   ram_waddr,
  output logic [BYTES*8-1:0]              ram_wdata,
  output logic                            commit,
  output logic [PW-1:0]                   commit_words,
  output logic [BYTES-1:0]                commit_keep,
  output logic                            frame_dropped
);

  localparam int LW  = eth_udp_length_width;
  localparam int LNW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [LNW-1:0]     lane_q, lane_d;
  logic [BYTES*8-1:0] word_q, word_d;
  logic [LW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]      len_q, len_d;
  logic               in_frame_q, in_frame_d;
  logic               drop_q, drop_d;
  logic [PW-1:0]      wr_spec_q, wr_spec_d;
  logic [PW-1:0]      wr_commit_q, wr_commit_d;
  logic               dropped_q, dropped_d;

  logic               first;
  logic [LNW-1:0]     lane;
  logic [BYTES*8-1:0] word_new;
  logic [BYTES-1:0]   keep_new;
  logic [LW-1:0]      len_cur;
  logic [LW-1:0]      cnt_new;
  logic               drop_new;
  logic               wr_needed;
  logic               ram_full;
  logic [PW-1:0]      wr_spec_inc;

  always_comb begin
    lane_d       = lane_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    in_frame_d   = in_frame_q;
    drop_d       = drop_q;
    wr_spec_d    = wr_spec_q;
    wr_commit_d  = wr_commit_q;
    dropped_d    = 1'b0;
    ram_we       = 1'b0;
    commit       = 1'b0;
    commit_words = '0;
    commit_keep  = '0;
    // The first byte of a frame restarts lane, count and drop state from scratch.
    first        = !in_frame_q;
    lane         = first ? '0 : lane_q;
    len_cur      = first ? udp_length : len_q;
    cnt_new      = first ? LW'(1) : ((&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + LW'(1));
    word_new     = first ? '0 : word_q;
    for (int j = 0; j < BYTES; j++) begin
      if (LNW'(j) == lane) word_new[j*8 +: 8] = udp_data;
      keep_new[j] = (LNW'(j) <= lane);
    end
    // Occupancy uses the registered read pointer; a read this cycle frees nothing yet.
    ram_full     = (wr_spec_q - rd_ptr) == PW'(DATA_DEPTH);
    wr_needed    = (lane == LNW'(BYTES - 1)) || udp_last;
    drop_new     = (!first && drop_q) || (wr_needed && ram_full);
    ram_waddr    = wr_spec_q[AW-1:0];
    ram_wdata    = word_new;
    wr_spec_inc  = wr_spec_q;

    if (udp_valid) begin
      ram_we      = wr_needed && !drop_new;
      wr_spec_inc = wr_spec_q + PW'(ram_we);
      if (udp_last) begin
        if (!drop_new && cnt_new == len_cur && !frame_full) begin
          commit       = 1'b1;
          commit_words = wr_spec_inc - wr_commit_q;
          commit_keep  = keep_new;
          wr_spec_d    = wr_spec_inc;
          wr_commit_d  = wr_spec_inc;
        end else begin
          wr_spec_d = wr_commit_q;
          dropped_d = 1'b1;
        end
        in_frame_d = 1'b0;
        lane_d     = '0;
        word_d     = '0;
        drop_d     = 1'b0;
        byte_cnt_d = '0;
      end else begin
        in_frame_d = 1'b1;
        len_d      = len_cur;
        byte_cnt_d = cnt_new;
        drop_d     = drop_new;
        wr_spec_d  = wr_spec_inc;
        lane_d     = wr_needed ? '0 : lane + LNW'(1);
        word_d     = wr_needed ? '0 : word_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= '0;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      in_frame_q  <= 1'b0;
      drop_q      <= 1'b0;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      dropped_q   <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      in_frame_q  <= in_frame_d;
      drop_q      <= drop_d;
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      dropped_q   <= dropped_d;
    end
  end

  assign frame_dropped = dropped_q;

endmodule

// File: rtl/udp_to_axi.sv
// Store-and-forward UDP payload to AXI-stream converter: data RAM, frame FIFO and
// an output read FSM feeding a two-entry skid buffer.
module udp_to_axi
  import eth_pkg::*;
#(
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int DATA_FIFO_DEPTH  = 4096,
  parameter int FRAME_FIFO_DEPTH = 64
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [eth_udp_length_width-1:0] Udp_length,
  input  logic [7:0]                      Udp_data,
  input  logic                            Udp_valid,
  input  logic                            Udp_last,
  output logic                            M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]       M_axis_data,
  output logic [AXI_DATA_WIDTH/8-1:0]     M_axis_keep,
  output logic                            M_axis_last,
  input  logic                            M_axis_ready,
  output logic                            Frame_dropped,
  output rd_state_e                       Dbg_rd_state
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int AW    = $clog2(DATA_FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int FAW   = $clog2(FRAME_FIFO_DEPTH);
  localparam int FPW   = FAW + 1;

  typedef struct packed {
    logic [PW-1:0]    word_count;
    logic [BYTES-1:0] last_keep;
  } frame_entry_t;

  logic                      ram_we;
  logic [AW-1:0]             ram_waddr;
  logic [AXI_DATA_WIDTH-1:0] ram_wdata;
  logic                      commit;
  logic [PW-1:0]             commit_words;
  logic [BYTES-1:0]          commit_keep;
  logic                      frame_full;

  udp_to_axi_packer #(
    .BYTES      (BYTES),
    .DATA_DEPTH (DATA_FIFO_DEPTH)
  ) u_packer (
    .clk           (Clk),
    .rst           (Rst),
    .udp_length    (Udp_length),
    .udp_data      (Udp_data),
    .udp_valid     (Udp_valid),
    .udp_last      (Udp_last),
    .rd_ptr        (rd_ptr_q),
    .frame_full    (frame_full),
    .ram_we        (ram_we),
    .ram_waddr     (ram_waddr),
    .ram_wdata     (ram_wdata),
    .commit        (commit),
    .commit_words  (commit_words),
    .commit_keep   (commit_keep),
    .frame_dropped (Frame_dropped)
  );

  logic [AXI_DATA_WIDTH-1:0] mem_q [DATA_FIFO_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] rd_data_q;
  frame_entry_t              ff_mem_q [FRAME_FIFO_DEPTH];
  frame_entry_t              ff_head;
  logic [FPW-1:0]            ff_wr_q, ff_wr_d, ff_rd_q, ff_rd_d;
  logic [FPW-1:0]            pending_q, pending_d;
  logic                      ff_empty, ff_pop;

  rd_state_e                 state_q, state_d;
  logic [PW-1:0]             remaining_q, remaining_d;
  logic [BYTES-1:0]          cur_keep_q, cur_keep_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      rd_last_q, rd_last_d;
  logic [BYTES-1:0]          rd_keep_q, rd_keep_d;
  logic                      rd_en, can_issue;

  logic [AXI_DATA_WIDTH-1:0] ob_data_q [2];
  logic [BYTES-1:0]          ob_keep_q [2];
  logic                      ob_last_q [2];
  logic                      ob_head_q, ob_head_d;
  logic [1:0]                ob_cnt_q, ob_cnt_d;
  logic                      ob_wr_idx, out_fire;

  // A frame slot stays taken until its last word is accepted downstream.
  assign ff_empty   = (ff_wr_q == ff_rd_q);
  assign frame_full = (pending_q == FPW'(FRAME_FIFO_DEPTH));
  assign ff_head    = ff_mem_q[ff_rd_q[FAW-1:0]];

  // Handshake: a word moves when M_axis_valid and M_axis_ready are both high on a clock
  // edge; while valid is high and ready low, data/keep/last come from an unchanged skid entry.
  assign M_axis_valid = (ob_cnt_q != 2'd0);
  assign M_axis_data  = M_axis_valid ? ob_data_q[ob_head_q] : '0;
  assign M_axis_keep  = M_axis_valid ? ob_keep_q[ob_head_q] : '0;
  assign M_axis_last  = M_axis_valid ? ob_last_q[ob_head_q] : 1'b0;
  assign Dbg_rd_state = state_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_keep_d  = cur_keep_q;
    rd_ptr_d    = rd_ptr_q;
    rd_vld_d    = 1'b0;
    rd_last_d   = rd_last_q;
    rd_keep_d   = rd_keep_q;
    rd_en       = 1'b0;
    ff_pop      = 1'b0;
    out_fire    = M_axis_valid && M_axis_ready;
    // Issue a read only if the skid buffer can absorb it when it lands next cycle.
    can_issue   = ({1'b0, ob_cnt_q} + {2'b00, rd_vld_q}) <= ({2'b00, out_fire} + 3'd1);
    unique case (state_q)
      RD_IDLE: begin
        if (!ff_empty) begin
          ff_pop      = 1'b1;
          remaining_d = ff_head.word_count;
          cur_keep_d  = ff_head.last_keep;
          state_d     = RD_DATA;
        end
      end
      RD_DATA: begin
        if (can_issue) begin
          rd_en       = 1'b1;
          rd_ptr_d    = rd_ptr_q + PW'(1);
          rd_vld_d    = 1'b1;
          rd_last_d   = (remaining_q == PW'(1));
          rd_keep_d   = (remaining_q == PW'(1)) ? cur_keep_q : '1;
          remaining_d = remaining_q - PW'(1);
          if (remaining_q == PW'(1)) begin
            if (!ff_empty) begin
              ff_pop      = 1'b1;
              remaining_d = ff_head.word_count;
              cur_keep_d  = ff_head.last_keep;
            end else begin
              state_d = RD_IDLE;
            end
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    ff_wr_d   = ff_wr_q + FPW'(commit);
    ff_rd_d   = ff_rd_q + FPW'(ff_pop);
    pending_d = pending_q + FPW'(commit) - FPW'(out_fire && M_axis_last);
    ob_wr_idx = ob_head_q ^ ob_cnt_q[0];
    ob_head_d = ob_head_q ^ out_fire;
    ob_cnt_d  = ob_cnt_q + {1'b0, rd_vld_q} - {1'b0, out_fire};
  end

  always_ff @(posedge Clk) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    if (rd_en) rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
    if (commit) ff_mem_q[ff_wr_q[FAW-1:0]] <= '{word_count: commit_words, last_keep: commit_keep};
    if (rd_vld_q) begin
      ob_data_q[ob_wr_idx] <= rd_data_q;
      ob_keep_q[ob_wr_idx] <= rd_keep_q;
      ob_last_q[ob_wr_idx] <= rd_last_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ff_wr_q     <= '0;
      ff_rd_q     <= '0;
      pending_q   <= '0;
      state_q     <= RD_IDLE;
      remaining_q <= '0;
      cur_keep_q  <= '0;
      rd_ptr_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_keep_q   <= '0;
      ob_head_q   <= 1'b0;
      ob_cnt_q    <= 2'd0;
    end else begin
      ff_wr_q     <= ff_wr_d;
      ff_rd_q     <= ff_rd_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_keep_q  <= cur_keep_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      rd_keep_q   <= rd_keep_d;
      ob_head_q   <= ob_head_d;
      ob_cnt_q    <= ob_cnt_d;
    end
  end

endmodule

// File: tb/tb_udp_to_axi.sv
// Self-checking bench for udp_to_axi: frame-level reference model feeding an expected-word
// queue, with an independent output monitor comparing every accepted AXI word.
module tb_udp_to_axi;
  import eth_pkg::*;

  localparam int W      = 32;
  localparam int BYTES  = W / 8;
  localparam int DEPTH  = 128;
  localparam int FDEPTH = 64;
  localparam int EW     = W + BYTES + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      udp_length;
  logic [7:0]       udp_data;
  logic             udp_valid;
  logic             udp_last;
  logic             m_valid;
  logic [W-1:0]     m_data;
  logic [BYTES-1:0] m_keep;
  logic             m_last;
  logic             m_ready;
  logic             frame_dropped;
  rd_state_e        dbg_state;

  udp_to_axi #(
    .AXI_DATA_WIDTH   (W),
    .DATA_FIFO_DEPTH  (DEPTH),
    .FRAME_FIFO_DEPTH (FDEPTH)
  ) dut (
    .Clk           (clk),
    .Rst           (rst),
    .Udp_length    (udp_length),
    .Udp_data      (udp_data),
    .Udp_valid     (udp_valid),
    .Udp_last      (udp_last),
    .M_axis_valid  (m_valid),
    .M_axis_data   (m_data),
    .M_axis_keep   (m_keep),
    .M_axis_last   (m_last),
    .M_axis_ready  (m_ready),
    .Frame_dropped (frame_dropped),
    .Dbg_rd_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    frame_bytes[$];
  int errors = 0;
  int checks = 0;
  int drops_seen = 0;
  int exp_drops = 0;
  int outstanding = 0;
  int ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Ready generator
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Scoreboard monitor
  logic [EW-1:0] prev_beat;
  logic          prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] beat;
    logic [EW-1:0] exp;
    beat = {m_last, m_keep, m_data};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_dropped) drops_seen++;
      if (prev_stall) check("axi_hold", {m_valid, beat}, {1'b1, prev_beat});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", beat);
        end else begin
          exp = exp_q.pop_front();
          check("axi_word", beat, exp);
          if (exp[EW-1]) outstanding--;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = beat;
    end
  end

  // Reference model: a frame passes iff its byte count matches the length, it fits in the
  // data buffer, and fewer than FDEPTH frames are awaiting delivery.
  task automatic send_frame(input int len_field, input int gap_pct);
    int n;
    int words;
    bit good;
    logic [W-1:0] d;
    logic [BYTES-1:0] k;
    n     = frame_bytes.size();
    words = (n + BYTES - 1) / BYTES;
    good  = (n == len_field) && (words <= DEPTH) && (outstanding < FDEPTH);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        udp_valid = 1'b0;
        udp_last  = 1'b0;
        @(posedge clk);
        #1;
      end
      udp_valid  = 1'b1;
      udp_data   = frame_bytes[i];
      udp_last   = (i == n - 1);
      udp_length = 16'(len_field);
      @(posedge clk);
      #1;
    end
    udp_valid = 1'b0;
    udp_last  = 1'b0;
    if (good) begin
      for (int w = 0; w < words; w++) begin
        d = '0;
        k = '0;
        for (int b = 0; b < BYTES; b++) begin
          if (w * BYTES + b < n) begin
            d[b*8 +: 8] = frame_bytes[w * BYTES + b];
            k[b]        = 1'b1;
          end
        end
        exp_q.push_back({(w == words - 1), k, d});
      end
      outstanding++;
    end else begin
      exp_drops++;
    end
  endtask

  task automatic fill_random(input int n);
    frame_bytes.delete();
    for (int i = 0; i < n; i++) frame_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (6) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int len;
    rst        = 1'b1;
    udp_valid  = 1'b0;
    udp_last   = 1'b0;
    udp_data   = 8'h00;
    udp_length = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_keep", m_keep, 0);
    check("rst_last", m_last, 0);
    check("rst_dropped", frame_dropped, 0);
    check("rst_state", dbg_state, RD_IDLE);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic 5-byte frame and first-word latency
    frame_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(5, 0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        lat = i;
        break;
      end
    end
    check("latency_in_window", (lat >= 2 && lat <= 4), 1);
    wait_drain("drain_basic");
    check("drops_basic", drops_seen, exp_drops);

    // Short frame fails the length check; the next frame is intact
    fill_random(6);
    send_frame(8, 0);
    frame_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_frame(4, 0);
    wait_drain("drain_len");
    check("drops_len", drops_seen, exp_drops);

    // Oversize frame dropped, exactly-full frame accepted
    ready_pct = 0;
    repeat (3) @(posedge clk);
    #1;
    fill_random(DEPTH * BYTES + 8);
    send_frame(DEPTH * BYTES + 8, 0);
    fill_random(DEPTH * BYTES);
    send_frame(DEPTH * BYTES, 0);
    repeat (5) @(posedge clk);
    #1;
    check("drops_oversize", drops_seen, exp_drops);
    ready_pct = 100;
    wait_drain("drain_full");

    // Frame FIFO limit: FDEPTH+1 one-byte frames with output stalled
    ready_pct = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < FDEPTH + 1; i++) begin
      frame_bytes = '{8'(i + 16)};
      send_frame(1, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("drops_frame_fifo", drops_seen, exp_drops);
    ready_pct = 100;
    wait_drain("drain_frames");

    // Reset in the middle of a frame with a committed frame waiting
    ready_pct = 0;
    repeat (3) @(posedge clk);
    #1;
    frame_bytes = '{8'h11, 8'h22, 8'h33};
    send_frame(3, 0);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_valid", m_valid, 1);
    for (int i = 0; i < 3; i++) begin
      udp_valid  = 1'b1;
      udp_data   = 8'(8'h40 + i);
      udp_last   = 1'b0;
      udp_length = 16'd8;
      @(posedge clk);
      #1;
    end
    udp_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_keep", m_keep, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_dropped", frame_dropped, 0);
    rst = 1'b0;
    exp_q.delete();
    outstanding = 0;
    fill_random(5);
    send_frame(8, 0);
    fill_random(7);
    send_frame(7, 0);
    ready_pct = 100;
    wait_drain("drain_rst");
    check("drops_rst", drops_seen, exp_drops);

    // Random frames, 80% ready, random byte gaps, some bad lengths
    ready_pct = 80;
    for (int f = 0; f < 80; f++) begin
      n = $urandom_range(1, 48);
      fill_random(n);
      len = n;
      if ($urandom_range(0, 99) < 15) begin
        if (n > 1 && $urandom_range(0, 1) == 1) len = n - 1;
        else len = n + $urandom_range(1, 4);
      end
      send_frame(len, 15);
    end
    wait_drain("drain_random");
    check("drops_random", drops_seen, exp_drops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
